// File: rtl/sysid_boot_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysid_boot_checker_pkg : FSM state type and sysid word addresses.
// Rev 1.0
// ---------------------------------------------------------------------------
package sysid_boot_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_RD_TS  = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysid_boot_checker : reads sysid words 0/1 over Avalon-MM and checks them.
// Optional macro SYSID_BOOT_CHECKER_RECHECK_EN adds periodic rechecks. Rev 1.0
// ---------------------------------------------------------------------------
module sysid_boot_checker
    import sysid_boot_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS      = 32'd1687961550,
    parameter int unsigned READ_LATENCY     = 0,
    parameter int unsigned TIMEOUT_CYCLES   = 255,
    parameter int unsigned RECHECK_INTERVAL = 50_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned LAT_W   = $clog2(READ_LATENCY) + 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY - 1);

    state_t             state;
    logic [STALL_W-1:0] stall_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               go;

`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    localparam int unsigned RC_W = $clog2(RECHECK_INTERVAL) + 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECHECK_INTERVAL - 1);

    logic            rc_armed;
    logic            rc_pending;
    logic [RC_W-1:0] rc_cnt;

    // Interval runs free once the first check has finished; a pending
    // recheck waits for IDLE so an expiry during a check is not lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rc_armed   <= 1'b0;
            rc_pending <= 1'b0;
            rc_cnt     <= '0;
        end else begin
            if (state == ST_FIN) begin
                rc_armed <= 1'b1;
            end
            if (rc_armed) begin
                rc_cnt <= (rc_cnt == RC_LAST) ? '0 : rc_cnt + 1'b1;
            end
            if (rc_armed && (rc_cnt == RC_LAST)) begin
                rc_pending <= 1'b1;
            end else if (state == ST_IDLE) begin
                rc_pending <= 1'b0;
            end
        end
    end

    assign go = start | rc_pending;
`else
    assign go = start;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state       <= ST_RD_ID;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        stall_cnt   <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        stall_cnt <= '0;
                        if (READ_LATENCY == 0) begin
                            id_value    <= avm_readdata;
                            avm_address <= SYSID_ADDR_TS;
                            state       <= ST_RD_TS;
                        end else begin
                            avm_read <= 1'b0;
                            lat_cnt  <= '0;
                            state    <= ST_LAT_ID;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        // Word 0 never read: its mismatch flag stays clear.
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_FIN;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                ST_LAT_ID: begin
                    if (lat_cnt == LAT_LAST) begin
                        id_value    <= avm_readdata;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_TS;
                        stall_cnt   <= '0;
                        state       <= ST_RD_TS;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            ts_value    <= avm_readdata;
                            id_mismatch <= (id_value != EXPECTED_ID);
                            ts_mismatch <= (avm_readdata != EXPECTED_TS);
                            pass        <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
                            done        <= 1'b1;
                            state       <= ST_FIN;
                        end else begin
                            lat_cnt <= '0;
                            state   <= ST_LAT_TS;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        avm_read    <= 1'b0;
                        timeout     <= 1'b1;
                        id_mismatch <= (id_value != EXPECTED_ID);
                        done        <= 1'b1;
                        state       <= ST_FIN;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                ST_LAT_TS: begin
                    if (lat_cnt == LAT_LAST) begin
                        ts_value    <= avm_readdata;
                        id_mismatch <= (id_value != EXPECTED_ID);
                        ts_mismatch <= (avm_readdata != EXPECTED_TS);
                        pass        <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
                        done        <= 1'b1;
                        state       <= ST_FIN;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sysid_boot_checker : scoreboard bench; instance 1 uses READ_LATENCY=2,
// instance 2 is reserved for the SYSID_BOOT_CHECKER_RECHECK_EN interval. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1687961550;
    localparam int          TMO    = 8;

    typedef struct {
        int          sel;
        logic        pass_e;
        logic        idm;
        logic        tsm;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
    } exp_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  start   = '0;
    logic [2:0]  avm_address, avm_read, wreq, busy, done, pass, id_mm, ts_mm, timeout;
    logic [31:0] id_value [3];
    logic [31:0] ts_value [3];

    logic [31:0] sl_id [3];
    logic [31:0] sl_ts [3];
    int          stall_n [3];
    bit          stuck [3];
    logic [31:0] last_id [3];
    logic [31:0] last_ts [3];

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          LAT = (g == 1) ? 2 : 0;
        localparam int unsigned RC  = (g == 2) ? 20 : 50_000_000;

        int          scnt = 0;
        logic [1:0]  pv   = '0;
        logic [1:0]  pa   = '0;
        logic [31:0] rdata;

        sysid_boot_checker #(
            .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT),
            .TIMEOUT_CYCLES(TMO), .RECHECK_INTERVAL(RC)
        ) u_dut (
            .clock(clock), .reset_n(reset_n), .start(start[g]),
            .avm_address(avm_address[g]), .avm_read(avm_read[g]),
            .avm_waitrequest(wreq[g]), .avm_readdata(rdata),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .id_mismatch(id_mm[g]), .ts_mismatch(ts_mm[g]), .timeout(timeout[g]),
            .id_value(id_value[g]), .ts_value(ts_value[g])
        );

        // Slave model: stall_n wait states per read, data LAT cycles after accept.
        always @(posedge clock) begin
            if (!avm_read[g])   scnt <= 0;
            else if (wreq[g])   scnt <= scnt + 1;
            else                scnt <= 0;
            pv <= {pv[0], avm_read[g] && !wreq[g]};
            pa <= {pa[0], avm_address[g]};
        end

        assign wreq[g] = avm_read[g] && (stuck[g] || (scnt < stall_n[g]));

        always_comb begin
            if (LAT == 0) rdata = avm_address[g] ? sl_ts[g] : sl_id[g];
            else          rdata = pv[1] ? (pa[1] ? sl_ts[g] : sl_id[g]) : 32'hDEAD_BEEF;
        end
    end

    function automatic int lat_of(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction

    // Runs one check on instance sel; expectation is queued before start and
    // popped when done appears.
    task automatic drive_and_score(input int sel, input logic [31:0] idw, input logic [31:0] tsw,
                                   input int stalls, input bit stk, input int inject_at,
                                   input bit fin_start);
        exp_t e, got;
        int   n;
        bit   a1, unstable, prd, pwr, pad, queued;
        sl_id[sel] = idw; sl_ts[sel] = tsw; stall_n[sel] = stalls; stuck[sel] = stk;
        e.sel = sel;
        if (stk) begin
            e.to = 1'b1; e.idm = 1'b0; e.tsm = 1'b0; e.pass_e = 1'b0;
            e.idv = last_id[sel]; e.tsv = last_ts[sel]; e.lat = TMO + 1;
        end else begin
            e.to = 1'b0; e.idm = (idw != EXP_ID); e.tsm = (tsw != EXP_TS);
            e.pass_e = !e.idm && !e.tsm; e.idv = idw; e.tsv = tsw;
            e.lat = 3 + 2 * stalls + 2 * lat_of(sel);
            last_id[sel] = idw; last_ts[sel] = tsw;
        end
        sb.push_back(e);

        @(negedge clock); start[sel] = 1'b1;
        @(negedge clock); start[sel] = 1'b0; n = 1;
        tests++;
        if (busy[sel] !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b expected 1", busy[sel]); end
        a1 = 0; unstable = 0; prd = 0; pwr = 0; pad = 0;
        while (!done[sel] && n < 100) begin
            if (avm_read[sel] && avm_address[sel]) a1 = 1;
            if (prd && pwr && !stk && !(avm_read[sel] === 1'b1 && avm_address[sel] === pad)) unstable = 1;
            prd = avm_read[sel]; pwr = wreq[sel]; pad = avm_address[sel];
            start[sel] = (n == inject_at);
            @(negedge clock); n++;
        end
        start[sel] = fin_start;

        tests++;
        if (done[sel] !== 1'b1) begin
            fails++; $display("FAIL done_seen: got no done after %0d cycles, expected at %0d", n, e.lat);
        end else if (sb.size() == 0) begin
            fails++; $display("FAIL scoreboard: got done with empty queue, expected an entry");
        end else begin
            got = sb.pop_front();
            tests++; if (n != got.lat) begin fails++; $display("FAIL latency[%0d]: got %0d expected %0d", sel, n, got.lat); end
            tests++; if (pass[sel] !== got.pass_e) begin fails++; $display("FAIL pass[%0d]: got %b expected %b", sel, pass[sel], got.pass_e); end
            tests++; if (id_mm[sel] !== got.idm) begin fails++; $display("FAIL id_mismatch[%0d]: got %b expected %b", sel, id_mm[sel], got.idm); end
            tests++; if (ts_mm[sel] !== got.tsm) begin fails++; $display("FAIL ts_mismatch[%0d]: got %b expected %b", sel, ts_mm[sel], got.tsm); end
            tests++; if (timeout[sel] !== got.to) begin fails++; $display("FAIL timeout[%0d]: got %b expected %b", sel, timeout[sel], got.to); end
            tests++; if (id_value[sel] !== got.idv) begin fails++; $display("FAIL id_value[%0d]: got %h expected %h", sel, id_value[sel], got.idv); end
            tests++; if (ts_value[sel] !== got.tsv) begin fails++; $display("FAIL ts_value[%0d]: got %h expected %h", sel, ts_value[sel], got.tsv); end
        end
        if (stk) begin
            tests++; if (a1) begin fails++; $display("FAIL no_ts_read: got address-1 read expected none"); end
        end else if (stalls > 0) begin
            tests++; if (unstable) begin fails++; $display("FAIL stall_stable: got changed read/address expected stable"); end
        end

        @(negedge clock); start[sel] = 1'b0;
        tests++;
        if (done[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
            fails++; $display("FAIL done_single: got done=%b busy=%b expected 0 0", done[sel], busy[sel]);
        end
        if (inject_at > 0 || fin_start) begin
            queued = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                if (busy[sel] || done[sel]) queued = 1;
            end
            tests++; if (queued) begin fails++; $display("FAIL start_dropped: got new check expected idle"); end
        end
    endtask

    task automatic test_reset;
        bit bad;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            bad = ({busy[s], done[s], pass[s], id_mm[s], ts_mm[s], timeout[s], avm_read[s], avm_address[s]} !== 8'b0)
                  || (id_value[s] !== 32'h0) || (ts_value[s] !== 32'h0);
            tests++; if (bad) begin fails++; $display("FAIL reset_outputs[%0d]: got nonzero output expected all 0", s); end
        end
        reset_n = 1'b1;
        @(negedge clock);
        tests++; if (busy !== 3'b0 || done !== 3'b0) begin fails++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 000", busy, done); end
    endtask

    task automatic test_pass;
        drive_and_score(0, EXP_ID, EXP_TS, 0, 0, 0, 0);
    endtask

    task automatic test_mismatch;
        drive_and_score(0, 32'h0000_0001, EXP_TS, 0, 0, 0, 0);
        drive_and_score(0, EXP_ID, EXP_TS ^ 32'h8000_0000, 0, 0, 0, 0);
    endtask

    task automatic test_stall_latency;
        drive_and_score(1, EXP_ID, EXP_TS, 3, 0, 0, 0);
        drive_and_score(1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 0, 0);
    endtask

    task automatic test_timeout;
        drive_and_score(0, EXP_ID, EXP_TS, 0, 1, 0, 0);
        stuck[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        drive_and_score(0, EXP_ID, EXP_TS, 0, 0, 0, 0);
        drive_and_score(0, EXP_ID, EXP_TS, 2, 0, 0, 0);
    endtask

    task automatic test_start_ignored;
        drive_and_score(0, EXP_ID, EXP_TS, 1, 0, 2, 1);
    endtask

    task automatic test_reset_mid_check;
        bit bad, saw_done;
        sl_id[0] = 32'hA5A5_0001; sl_ts[0] = EXP_TS; stall_n[0] = 3; stuck[0] = 1'b0;
        @(negedge clock); start[0] = 1'b1;
        @(negedge clock); start[0] = 1'b0;
        repeat (5) @(negedge clock);
        tests++;
        if (avm_read[0] !== 1'b1 || avm_address[0] !== 1'b1) begin
            fails++; $display("FAIL in_rd_ts: got read=%b addr=%b expected 1 1", avm_read[0], avm_address[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        bad = ({busy[0], done[0], pass[0], id_mm[0], ts_mm[0], timeout[0], avm_read[0], avm_address[0]} !== 8'b0)
              || (id_value[0] !== 32'h0) || (ts_value[0] !== 32'h0);
        tests++; if (bad) begin fails++; $display("FAIL async_reset: got nonzero output expected all 0"); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done[0] || busy[0]) saw_done = 1;
        end
        tests++; if (saw_done) begin fails++; $display("FAIL no_done_after_reset: got done/busy expected none"); end
        for (int s = 0; s < 3; s++) begin last_id[s] = '0; last_ts[s] = '0; end
    endtask

`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    task automatic test_recheck;
        int n, gap;
        drive_and_score(2, EXP_ID, EXP_TS, 0, 0, 0, 0);
        n = 0;
        while (!done[2] && n < 60) begin @(negedge clock); n++; end
        tests++; if (done[2] !== 1'b1) begin fails++; $display("FAIL recheck_first: got no done expected one within 60"); end
        @(negedge clock); gap = 1;
        while (!done[2] && gap < 60) begin @(negedge clock); gap++; end
        tests++; if (gap != 20) begin fails++; $display("FAIL recheck_gap: got %0d expected 20", gap); end
        tests++; if (pass[2] !== 1'b1) begin fails++; $display("FAIL recheck_pass: got %b expected 1", pass[2]); end
    endtask
`endif

    initial begin
        for (int s = 0; s < 3; s++) begin
            sl_id[s] = EXP_ID; sl_ts[s] = EXP_TS; stall_n[s] = 0; stuck[s] = 1'b0;
            last_id[s] = '0; last_ts[s] = '0;
        end
        test_reset();
        test_pass();
        test_mismatch();
        test_stall_latency();
        test_timeout();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_check();
`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
        test_recheck();
`endif
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
